// File: rtl/wh_router_pkg.sv
// Shared router definitions: port count, port index names and the switch-allocator FSM state type.
package wh_router_pkg;

  localparam int N_PORTS = 5;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_e;

  typedef enum logic {
    SA_IDLE   = 1'b0,
    SA_LOCKED = 1'b1
  } sa_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational wraparound priority pick: first requester at index >= prio, else lowest requester.
module rr_pick #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] prio,
  output logic [N-1:0]  pick,
  output logic          found
);

  logic [N-1:0] masked;
  logic [N-1:0] hi_pick;
  logic [N-1:0] lo_pick;

  // The masked stage covers indices from prio upward; the unmasked stage supplies the wrap to 0.
  always_comb begin
    masked  = '0;
    hi_pick = '0;
    lo_pick = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] && (PW'(i) >= prio);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) begin
        hi_pick    = '0;
        hi_pick[i] = 1'b1;
      end
      if (req[i]) begin
        lo_pick    = '0;
        lo_pick[i] = 1'b1;
      end
    end
  end

  assign pick  = (|masked) ? hi_pick : lo_pick;
  assign found = |req;

endmodule

// File: rtl/wh_sa_outport_ctrl.sv
// Wormhole switch-allocator output-port controller: locks the output to one packet head-to-tail.
// Optional stall watchdog and stall_err_o port are built when WH_SA_WATCHDOG_EN is defined.
module wh_sa_outport_ctrl
  import wh_router_pkg::*;
#(
  parameter int N          = 5,
  parameter int WDOG_LIMIT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] head_i,
  input  logic [N-1:0] tail_i,
  input  logic         out_ready_i,
  output logic [N-1:0] grant_o,
  output logic         xfer_o,
  output logic         busy_o
`ifdef WH_SA_WATCHDOG_EN
  ,
  output logic         stall_err_o
`endif
);

  localparam int PW = $clog2(N);

  sa_state_t     state, state_nxt;
  logic [PW-1:0] owner, owner_nxt;
  logic [PW-1:0] prio, prio_nxt;
  logic [N-1:0]  grant, grant_nxt;
  logic [N-1:0]  pick;
  logic          found;
  logic [PW-1:0] pick_idx;
  logic          release_lock;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req   (req_i & head_i),
    .prio  (prio),
    .pick  (pick),
    .found (found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  assign xfer_o       = (state == SA_LOCKED) && req_i[owner] && out_ready_i;
  assign release_lock = xfer_o && tail_i[owner];
  assign grant_o      = grant;
  assign busy_o       = (state == SA_LOCKED);

  // A release cycle returns to IDLE without arbitrating; the next grant comes from the IDLE cycle.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    prio_nxt  = prio;
    grant_nxt = grant;
    case (state)
      SA_IDLE: begin
        if (found) begin
          state_nxt = SA_LOCKED;
          owner_nxt = pick_idx;
          grant_nxt = pick;
        end
      end
      SA_LOCKED: begin
        if (release_lock) begin
          state_nxt = SA_IDLE;
          grant_nxt = '0;
          prio_nxt  = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: begin
        state_nxt = SA_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SA_IDLE;
      owner <= '0;
      prio  <= '0;
      grant <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      prio  <= prio_nxt;
      grant <= grant_nxt;
    end
  end

`ifdef WH_SA_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_LIMIT + 1);

  logic [CW-1:0] wdog_cnt;
  logic          stalled;

  assign stalled = (state == SA_LOCKED) && !xfer_o;

  // Counter saturates at the limit; the flag stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt    <= '0;
      stall_err_o <= 1'b0;
    end else begin
      if (!stalled) begin
        wdog_cnt <= '0;
      end else if (wdog_cnt != CW'(WDOG_LIMIT)) begin
        wdog_cnt <= wdog_cnt + 1'b1;
        if (wdog_cnt + 1'b1 == CW'(WDOG_LIMIT)) stall_err_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wh_sa_outport_ctrl.sv
// Randomized and directed self-checking bench for wh_sa_outport_ctrl against a packet-level reference model.
module tb_wh_sa_outport_ctrl;

  localparam int N    = 5;
  localparam int WLIM = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_i, head_i, tail_i;
  logic         out_ready_i;
  logic [N-1:0] grant_o;
  logic         xfer_o, busy_o;
`ifdef WH_SA_WATCHDOG_EN
  logic         stall_err_o;
`endif

  wh_sa_outport_ctrl #(.N(N), .WDOG_LIMIT(WLIM)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .head_i      (head_i),
    .tail_i      (tail_i),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .xfer_o      (xfer_o),
    .busy_o      (busy_o)
`ifdef WH_SA_WATCHDOG_EN
    ,
    .stall_err_o (stall_err_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: packet-level view of the output port.
  bit m_known  = 0;
  bit m_locked = 0;
  int m_owner  = 0;
  int m_prio   = 0;
  int m_cnt    = 0;
  bit m_stall  = 0;
  bit obs_xfer;
  int obs_owner;
  int xfer_count;

  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] hd,
                     input logic [N-1:0] tl, input logic rdy);
    bit          exp_xfer;
    logic [N-1:0] cand;
    @(negedge clk);
    rst = r; req_i = rq; head_i = hd; tail_i = tl; out_ready_i = rdy;
    #1;
    exp_xfer = m_locked && rq[m_owner] && rdy;
    if (m_known) begin
      chk("xfer",   xfer_o,  exp_xfer);
      chk("grant",  grant_o, m_locked ? (32'd1 << m_owner) : 32'd0);
      chk("busy",   busy_o,  m_locked);
      chk("onehot", $onehot0(grant_o), 1);
`ifdef WH_SA_WATCHDOG_EN
      chk("stall",  stall_err_o, m_stall);
`endif
    end
    obs_xfer  = xfer_o;
    obs_owner = -1;
    for (int i = 0; i < N; i++) if (grant_o[i]) obs_owner = i;
    if (obs_xfer) xfer_count++;
    if (r) begin
      m_known = 1; m_locked = 0; m_owner = 0; m_prio = 0; m_cnt = 0; m_stall = 0;
    end else begin
      if (m_locked && !exp_xfer) begin
        if (m_cnt < WLIM) m_cnt++;
        if (m_cnt == WLIM) m_stall = 1;
      end else begin
        m_cnt = 0;
      end
      if (m_locked) begin
        if (exp_xfer && tl[m_owner]) begin
          m_locked = 0;
          m_prio   = (m_owner + 1) % N;
        end
      end else begin
        cand = rq & hd;
        for (int k = 0; k < N; k++) begin
          if (!m_locked && cand[(m_prio + k) % N]) begin
            m_locked = 1;
            m_owner  = (m_prio + k) % N;
          end
        end
      end
    end
  endtask

  int order_q[$];
  int exp_order[6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    rst = 1'b1; req_i = '0; head_i = '0; tail_i = '0; out_ready_i = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_busy",  busy_o,  0);

    // Heads on 1 and 3 with prio 0: input 1 wins one cycle later.
    cyc(0, 5'b01010, 5'b01010, 0, 0);
    cyc(0, 5'b01010, 5'b01010, 0, 0);
    chk("first_grant", grant_o, 5'b00010);

    // Four-flit packet from input 1 while input 3 waits with a head.
    xfer_count = 0;
    cyc(0, 5'b01010, 5'b01010, 5'b00000, 1);
    cyc(0, 5'b01010, 5'b01000, 5'b00000, 1);
    cyc(0, 5'b01010, 5'b01000, 5'b00000, 1);
    cyc(0, 5'b01010, 5'b01000, 5'b00010, 1);
    chk("pkt_xfers", xfer_count, 4);
    cyc(0, 5'b01000, 5'b01000, 0, 0);
    chk("rel_grant0", grant_o, 0);
    cyc(0, 5'b01000, 5'b01000, 0, 0);
    chk("next_grant", grant_o, 5'b01000);

    // Stalled downstream: grant holds while xfer follows ready.
    cyc(0, 5'b01000, 5'b01000, 0, 1);
    cyc(0, 5'b01000, 5'b00000, 0, 0);
    chk("hold_xfer", xfer_o, 0);
    cyc(0, 5'b11111, 5'b11111, 0, 0);
    chk("hold_grant", grant_o, 5'b01000);
    cyc(0, 5'b01000, 5'b00000, 0, 1);
    chk("resume_xfer", xfer_o, 1);
    cyc(0, 5'b01000, 5'b00000, 5'b01000, 1);

    // Back-to-back single-flit packets from every input, starting from prio 0.
    cyc(1, 0, 0, 0, 0);
    order_q.delete();
    for (int c = 0; c < 12; c++) begin
      cyc(0, 5'b11111, 5'b11111, 5'b11111, 1);
      if (obs_xfer) order_q.push_back(obs_owner);
    end
    chk("rr_count", order_q.size(), 6);
    for (int i = 0; i < 6 && i < order_q.size(); i++) chk("rr_order", order_q[i], exp_order[i]);

    // Body flit without a lock is ignored; reset mid-packet drops the lock.
    cyc(1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) cyc(0, 5'b00100, 5'b00000, 0, 1);
    chk("body_nogrant", grant_o, 0);
    cyc(0, 5'b00100, 5'b00100, 0, 1);
    cyc(0, 5'b00100, 5'b00100, 0, 1);
    cyc(0, 5'b00100, 5'b00000, 0, 1);
    chk("mid_grant", grant_o, 5'b00100);
    cyc(1, 5'b00100, 5'b00000, 0, 1);
    cyc(0, 5'b01010, 5'b01010, 0, 1);
    chk("rst_mid_grant", grant_o, 0);
    chk("rst_mid_busy",  busy_o,  0);
    chk("rst_mid_xfer",  xfer_o,  0);
    cyc(0, 5'b01010, 5'b01010, 5'b01010, 1);
    chk("post_rst_prio", grant_o, 5'b00010);

`ifdef WH_SA_WATCHDOG_EN
    // Locked owner never drained: flag rises after WLIM stalled cycles and sticks.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 5'b00001, 5'b00001, 0, 0);
    for (int c = 0; c < WLIM; c++) cyc(0, 5'b00001, 5'b00001, 0, 0);
    cyc(0, 5'b00001, 5'b00001, 5'b00001, 1);
    chk("wdog_set", stall_err_o, 1);
    cyc(0, 0, 0, 0, 0);
    chk("wdog_sticky", stall_err_o, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("wdog_clr", stall_err_o, 0);
`endif

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      cyc($urandom_range(249) == 0, N'($urandom), N'($urandom), N'($urandom),
          $urandom_range(3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wh_sa_outport_ctrl.md
WH_SA_OUTPORT_CTRL -- requirements
Module: wh_sa_outport_ctrl

Interface
REQ-001 SHALL have parameter N, default 5, number of input ports competing for this output port (N >= 2).
REQ-002 SHALL have parameter WDOG_LIMIT, default 64, locked cycles without a transfer before a stall is flagged (used only under WH_SA_WATCHDOG_EN).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_i  input  N  bit i: input i holds a valid flit routed to this output.
REQ-006 SHALL have port head_i  input  N  bit i: input i's front flit is a head flit.
REQ-007 SHALL have port tail_i  input  N  bit i: input i's front flit is a tail flit; head and tail both set means a single-flit packet.
REQ-008 SHALL have port out_ready_i  input  1  downstream buffer can accept a flit this cycle.
REQ-009 SHALL have port grant_o  output  N  registered one-hot owner of the output; all zero when unlocked.
REQ-010 SHALL have port xfer_o  output  1  a flit moves from the owner to the output this cycle.
REQ-011 SHALL have port busy_o  output  1  output is locked to a packet.
REQ-012 SHALL have port stall_err_o  output  1  watchdog stall flag; present only under WH_SA_WATCHDOG_EN.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-014 In IDLE, the candidate set SHALL be req_i & head_i; body and tail flits without a lock SHALL be ignored.
REQ-015 In IDLE with a non-empty candidate set, the block SHALL pick the first candidate at index >= prio, wrapping to 0. It SHALL register owner and grant_o and enter LOCKED on the next edge (1-cycle grant latency).
REQ-016 In LOCKED, xfer_o SHALL be combinational: req_i[owner] & out_ready_i. There SHALL be no transfer in IDLE.
REQ-017 In LOCKED, xfer_o & tail_i[owner] SHALL release the lock. Next state is IDLE, grant_o becomes 0, and prio becomes (owner+1) mod N, wrapping N-1 to 0.
REQ-018 prio SHALL change only on release. Ownership SHALL never change mid-packet, whatever the other requests are.
REQ-019 A release cycle SHALL NOT also arbitrate. A new grant appears no earlier than 2 cycles after the tail transfer.
REQ-020 A single-flit packet SHALL lock and release on its one transfer.
REQ-021 If req_i[owner] or out_ready_i is low in LOCKED, the block SHALL hold state, grant_o and prio unchanged.
REQ-022 busy_o SHALL be high exactly when the state is LOCKED.
REQ-023 grant_o SHALL always be zero or one-hot.

Reset
REQ-024 When rst is high at a clock edge, the block SHALL set state IDLE, grant_o 0, owner 0, prio 0, busy_o 0, watchdog count 0 and stall_err_o 0.
REQ-025 A reset during LOCKED SHALL drop the lock immediately with no release and no prio update. xfer_o SHALL be 0 in the cycle after reset.

Configuration
REQ-026 With macro WH_SA_WATCHDOG_EN defined, the watchdog SHALL operate as follows:
  - a counter increments each LOCKED cycle without xfer_o;
  - it clears on xfer_o or in IDLE;
  - stall_err_o goes high sticky when the count reaches WDOG_LIMIT;
  - only rst clears stall_err_o.
  The flag SHALL NOT affect arbitration.
REQ-027 Without WH_SA_WATCHDOG_EN, the port stall_err_o, the counter and WDOG_LIMIT usage SHALL be absent.

Structure
REQ-028 Shared package wh_router_pkg SHALL hold N_PORTS = 5, the port index enum (LOCAL, NORTH, EAST, SOUTH, WEST = 0..4) and the FSM state typedef sa_state_t.
REQ-029 Wraparound priority pick SHALL be sub-module rr_pick, which is combinational. It takes req[N] and prio and returns a one-hot pick[N] plus a found flag. Its masked/unmasked two-stage structure holds no state.

Verification
REQ-030 Reset, then head on inputs 1 and 3 with prio=0 -> grant_o=00010 one cycle later.
REQ-031 Owner 1 sends a 4-flit packet with out_ready_i=1 while input 3 holds a head -> exactly 4 xfer_o pulses, then grant_o=0. Two cycles after the tail, grant_o=01000 and prio=2 at release.
REQ-032 Locked owner with out_ready_i toggling 1,0,0,1 -> xfer_o follows it and grant_o stays constant.
REQ-033 All 5 inputs send back-to-back single-flit packets -> grant order 0,1,2,3,4,0 with no input granted twice before the others.
REQ-034 Body flit on input 2 with no lock -> no grant. rst mid-packet -> next cycle grant_o=0, busy_o=0 and prio unchanged.
REQ-035 With WH_SA_WATCHDOG_EN, WDOG_LIMIT=8 and owner locked with out_ready_i=0 -> stall_err_o rises after 8 locked cycles and stays high until rst.
